// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle RV32I controller: FSM
//            states, opcodes, ALU selects, ALUOp and datapath mux selects,
//            plus the opcode-to-immediate-format helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU selects
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // Operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, independent of state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_ITYPE, OP_LOAD: imm = IMM_I;
      OP_STORE:          imm = IMM_S;
      OP_BRANCH:         imm = IMM_B;
      OP_JAL:            imm = IMM_J;
      default:           imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational ALU select decode from ALUOp and function fields.
// Ports    : aluop[1:0]       - 00 add, 01 sub, 10 funct decode
//            funct3[2:0]      - instr[14:12]
//            op5              - instr[5], distinguishes R-type from I-type
//            funct7b5         - instr[30]
//            alu_control[2:0] - ALU select
//            funct_illegal    - funct3 not supported by the funct decode
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  logic [2:0] w_funct_alu;

  // funct_illegal is evaluated regardless of aluop so the FSM can screen the
  // instruction while still in DECODE (where the ALU is doing an add).
  always_comb begin
    w_funct_alu   = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct3)
      3'b000:  w_funct_alu = (op5 & funct7b5) ? ALU_SUB : ALU_ADD; // addi never subtracts
      3'b010:  w_funct_alu = ALU_SLT;
      3'b110:  w_funct_alu = ALU_OR;
      3'b111:  w_funct_alu = ALU_AND;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (aluop)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = w_funct_alu;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Main Moore controller for the multi-cycle RV32I core. Sequences
//            PC/IR/regfile/memory enables and drives ALU and mux selects.
// Ports    : clk, rst (async, active high)
//            op[6:0], funct3[2:0], funct7b5 - fields from the instr register
//            zero       - ALU zero flag of the current cycle
//            mem_ready  - memory access completes this cycle
//            pc_write, adr_src, mem_write, ir_write, reg_write - enables/selects
//            result_src[1:0], alu_src_a[1:0], alu_src_b[1:0]  - mux selects
//            alu_control[2:0], imm_src[1:0]                    - ALU / imm
//            instr_retired - pulse in last cycle of each instruction
//            illegal       - sticky illegal-instruction flag
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       w_mem_ready;
  logic [1:0] w_aluop;
  logic       w_funct_illegal;

  generate
    if (USE_MEM_READY != 0) begin : g_mem_ready_used
      assign w_mem_ready = mem_ready;
    end else begin : g_mem_ready_ignored
      logic w_mem_ready_unused;
      assign w_mem_ready_unused = mem_ready;
      assign w_mem_ready        = 1'b1;
    end
  endgenerate

  alu_decoder u_alu_decoder (
    .aluop        (w_aluop),
    .funct3       (funct3),
    .op5          (op[5]),
    .funct7b5     (funct7b5),
    .alu_control  (alu_control),
    .funct_illegal(w_funct_illegal)
  );

  assign imm_src = imm_src_of(op);
  assign illegal = illegal_q;

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (w_mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = w_funct_illegal ? TRAP : EXECUTER;
          OP_ITYPE:          state_d = w_funct_illegal ? TRAP : EXECUTEI;
          OP_BRANCH:         state_d = (funct3 != 3'b000) ? TRAP : BEQ;
          OP_JAL:            state_d = JAL;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (w_mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (w_mem_ready) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  // Flag rises together with the entry into TRAP so it is visible in the
  // first TRAP cycle.
  always_comb begin
    illegal_d = illegal_q | (state_d == TRAP);
  end

  // Moore outputs
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    w_aluop       = ALUOP_ADD;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_write   = w_mem_ready;
        ir_write   = w_mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src    = RES_MEMDATA;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = w_mem_ready;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        w_aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      BEQ: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        w_aluop       = ALUOP_SUB;
        pc_write      = zero;
        instr_retired = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset is asynchronous: suppress all side effects immediately rather
    // than waiting for the state register to be cleared.
    if (rst) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Purpose  : Self-checking bench for multicycle_ctrl_fsm. A per-instruction
//            model expands each directed instruction into its expected
//            cycle-by-cycle control words; one loop drives and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic       instr_retired, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  multicycle_ctrl_fsm #(.USE_MEM_READY(1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
    .instr_retired(instr_retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // One expected cycle: inputs to apply and the control word required.
  typedef struct packed {
    logic        rst;
    logic        mr;
    logic        zero;
    logic [31:0] instr;
    logic [17:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Control word layout: {pcw,adr,mw,irw,res[1:0],sa[1:0],sb[1:0],alu[2:0],imm[1:0],rw,ret,ill}
  function automatic logic [17:0] cw(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic [1:0] res,
      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
      input logic [1:0] imm, input logic rw, input logic ret, input logic ill);
    return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw, ret, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [31:0] instr);
    case (instr[6:0])
      7'h03, 7'h13: return 2'd0;
      7'h23:        return 2'd1;
      7'h63:        return 2'd2;
      7'h6F:        return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  // Supported subset: lw, sw, jal, add/sub/slt/or/and (+ immediates), beq.
  function automatic bit legal(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    case (instr[6:0])
      7'h03, 7'h23, 7'h6F: return 1'b1;
      7'h33, 7'h13:        return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
      7'h63:               return f3 == 3'd0;
      default:             return 1'b0;
    endcase
  endfunction

  // ALU operation implied by the arithmetic instruction's mnemonic.
  function automatic logic [2:0] alu_of(input logic [31:0] instr);
    case (instr[14:12])
      3'd0:    return (instr[6:0] == 7'h33 && instr[30]) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic r, input logic mr, input logic z,
                      input logic [31:0] instr, input logic [17:0] e);
    cyc_t c;
    c.rst = r; c.mr = mr; c.zero = z; c.instr = instr; c.exp = e;
    q.push_back(c);
  endtask

  task automatic add_reset(input logic [31:0] instr);
    push(1'b1, 1'b1, 1'b0, instr,
         cw(0,0,0,0,2'd2,2'd0,2'd2,3'd0,imm_of(instr),0,0,0));
  endtask

  task automatic add_fetch_decode(input logic [31:0] instr, input int fw, input logic z);
    logic [1:0] im;
    im = imm_of(instr);
    for (int i = 0; i < fw; i++)
      push(1'b0, 1'b0, z, instr, cw(0,0,0,0,2'd2,2'd0,2'd2,3'd0,im,0,0,0));
    push(1'b0, 1'b1, z, instr, cw(1,0,0,1,2'd2,2'd0,2'd2,3'd0,im,0,0,0));
    push(1'b0, 1'b1, z, instr, cw(0,0,0,0,2'd0,2'd1,2'd1,3'd0,im,0,0,0));
  endtask

  task automatic add_instr(input logic [31:0] instr, input int fw, input int mw, input logic z);
    logic [1:0] im;
    logic [2:0] a;
    im = imm_of(instr);
    a  = alu_of(instr);
    add_fetch_decode(instr, fw, z);
    if (!legal(instr)) begin
      for (int i = 0; i < 12; i++)
        push(1'b0, 1'b1, z, instr, cw(0,0,0,0,2'd0,2'd0,2'd0,3'd0,im,0,0,1));
      return;
    end
    case (instr[6:0])
      7'h03: begin
        push(1'b0, 1'b1, z, instr, cw(0,0,0,0,2'd0,2'd2,2'd1,3'd0,im,0,0,0));
        for (int i = 0; i < mw; i++)
          push(1'b0, 1'b0, z, instr, cw(0,1,0,0,2'd0,2'd0,2'd0,3'd0,im,0,0,0));
        push(1'b0, 1'b1, z, instr, cw(0,1,0,0,2'd0,2'd0,2'd0,3'd0,im,0,0,0));
        push(1'b0, 1'b1, z, instr, cw(0,0,0,0,2'd1,2'd0,2'd0,3'd0,im,1,1,0));
      end
      7'h23: begin
        push(1'b0, 1'b1, z, instr, cw(0,0,0,0,2'd0,2'd2,2'd1,3'd0,im,0,0,0));
        for (int i = 0; i < mw; i++)
          push(1'b0, 1'b0, z, instr, cw(0,1,1,0,2'd0,2'd0,2'd0,3'd0,im,0,0,0));
        push(1'b0, 1'b1, z, instr, cw(0,1,1,0,2'd0,2'd0,2'd0,3'd0,im,0,1,0));
      end
      7'h33, 7'h13: begin
        push(1'b0, 1'b1, z, instr,
             cw(0,0,0,0,2'd0,2'd2,(instr[6:0] == 7'h33) ? 2'd0 : 2'd1,a,im,0,0,0));
        push(1'b0, 1'b1, z, instr, cw(0,0,0,0,2'd0,2'd0,2'd0,3'd0,im,1,1,0));
      end
      7'h63:
        push(1'b0, 1'b1, z, instr, cw(z,0,0,0,2'd0,2'd2,2'd0,3'b001,im,0,1,0));
      default: begin // jal: PC <- target, then rd <- PC+4
        push(1'b0, 1'b1, z, instr, cw(1,0,0,0,2'd0,2'd1,2'd2,3'd0,im,0,0,0));
        push(1'b0, 1'b1, z, instr, cw(0,0,0,0,2'd0,2'd0,2'd0,3'd0,im,1,1,0));
      end
    endcase
  endtask

  task automatic pin(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  initial begin
    int          n0;
    int          retired_seen;
    logic [17:0] act;
    logic [31:0] sw_i;
    retired_seen = 0;
    sw_i = 32'h0010A023;

    add_reset(32'h0);
    add_reset(32'h0);

    n0 = q.size(); add_instr(32'h002081B3, 0, 0, 1'b0);
    pin("len_add", q.size() - n0, 4);
    pin("model_add_alu", int'(q[n0+2].exp[7:5]), 0);
    n0 = q.size(); add_instr(32'h40208133, 0, 0, 1'b0);
    pin("model_sub_alu", int'(q[n0+2].exp[7:5]), 1);
    n0 = q.size(); add_instr(32'h40008093, 0, 0, 1'b0);
    pin("model_addi_alu", int'(q[n0+2].exp[7:5]), 0);
    n0 = q.size(); add_instr(32'h0020A1B3, 0, 0, 1'b0);
    pin("model_slt_alu", int'(q[n0+2].exp[7:5]), 5);
    add_instr(32'h0020E1B3, 0, 0, 1'b0);
    add_instr(32'h0020F1B3, 0, 0, 1'b0);
    n0 = q.size(); add_instr(32'h0000A283, 0, 2, 1'b0);
    pin("len_lw_wait2", q.size() - n0, 7);
    n0 = q.size(); add_instr(sw_i, 0, 0, 1'b0);
    pin("len_sw", q.size() - n0, 4);
    add_instr(sw_i, 1, 1, 1'b0);
    n0 = q.size(); add_instr(32'h00208463, 0, 0, 1'b1);
    pin("len_beq", q.size() - n0, 3);
    add_instr(32'h00208463, 0, 0, 1'b0);
    n0 = q.size(); add_instr(32'h008000EF, 0, 0, 1'b0);
    pin("len_jal", q.size() - n0, 4);

    add_instr(32'h0000007F, 0, 0, 1'b0);   // unknown opcode
    add_reset(32'h0);
    add_instr(32'h00209133, 0, 0, 1'b0);   // R-type funct3=001
    add_reset(32'h0);
    add_instr(32'h00209463, 0, 0, 1'b0);   // branch funct3=001
    add_reset(32'h0);

    // sw interrupted by reset while waiting on memory
    add_fetch_decode(sw_i, 0, 1'b0);
    push(1'b0, 1'b1, 1'b0, sw_i, cw(0,0,0,0,2'd0,2'd2,2'd1,3'd0,2'd1,0,0,0));
    push(1'b0, 1'b0, 1'b0, sw_i, cw(0,1,1,0,2'd0,2'd0,2'd0,3'd0,2'd1,0,0,0));
    add_reset(sw_i);
    add_instr(32'h002081B3, 0, 0, 1'b0);

    foreach (q[i]) begin
      @(negedge clk);
      rst       = q[i].rst;
      mem_ready = q[i].mr;
      zero      = q[i].zero;
      op        = q[i].instr[6:0];
      funct3    = q[i].instr[14:12];
      funct7b5  = q[i].instr[30];
      #1;
      act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_control, imm_src, reg_write, instr_retired, illegal};
      checks++;
      if (act !== q[i].exp) begin
        errors++;
        $display("FAIL cycle%0d ctrl actual=%h required=%h", i, act, q[i].exp);
      end
      if (instr_retired === 1'b1) retired_seen++;
    end

    pin("retired_count", retired_seen, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
